// File: rtl/spi_slave_regbus.sv
// -----------------------------------------------------------------------------
// spi_slave_regbus
//
// SPI mode-0 responder that turns 16-bit host frames into single-cycle
// accesses on a simple parallel register bus. The SPI pins are oversampled
// in the p_in_clk domain; SCLK must not exceed p_in_clk/10.
//
// Frame (MSB first): [15] R/W (1 = read), [14:8] address, [7:0] data.
//
// Ports:
//   p_in_clk          system clock
//   p_in_rst_n        asynchronous active-low reset
//   p_in_spi_clk      SPI SCLK from host (asynchronous)
//   p_in_spi_cs_n     SPI chip select, active-low (asynchronous)
//   p_in_spi_mosi     SPI data from host
//   p_out_spi_miso    SPI data to host
//   p_out_spi_miso_oe MISO drive enable (1 = drive), follows synchronized CS
//   p_out_reg_addr    register address, holds between frames
//   p_out_reg_wdata   register write data, holds between frames
//   p_out_reg_wr      one-cycle write strobe
//   p_out_reg_rd      one-cycle read strobe
//   p_in_reg_rdata    read data, valid one cycle after p_out_reg_rd
//   p_out_frame_err   one-cycle pulse when a frame is aborted by CS rising
//   p_out_busy        synchronized CS asserted
// -----------------------------------------------------------------------------
module spi_slave_regbus #(
  parameter int unsigned G_SYNC_STAGES = 2,
  parameter logic        G_MISO_IDLE   = 1'b0
) (
  input  logic       p_in_clk,
  input  logic       p_in_rst_n,
  input  logic       p_in_spi_clk,
  input  logic       p_in_spi_cs_n,
  input  logic       p_in_spi_mosi,
  output logic       p_out_spi_miso,
  output logic       p_out_spi_miso_oe,
  output logic [6:0] p_out_reg_addr,
  output logic [7:0] p_out_reg_wdata,
  output logic       p_out_reg_wr,
  output logic       p_out_reg_rd,
  input  logic [7:0] p_in_reg_rdata,
  output logic       p_out_frame_err,
  output logic       p_out_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [G_SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [G_SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [G_SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  // vld_q[i] marks that stage i (index G_SYNC_STAGES = cs_prev_q) holds a real
  // pin sample rather than its reset value.
  logic [G_SYNC_STAGES:0]   vld_q,       vld_d;
  logic                     sclk_prev_q, sclk_prev_d;
  logic                     cs_prev_q,   cs_prev_d;
  logic                     armed_q,     armed_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[G_SYNC_STAGES-2:0], p_in_spi_clk};
    cs_sync_d   = {cs_sync_q[G_SYNC_STAGES-2:0],   p_in_spi_cs_n};
    mosi_sync_d = {mosi_sync_q[G_SYNC_STAGES-2:0], p_in_spi_mosi};
    vld_d       = {vld_q[G_SYNC_STAGES-1:0], 1'b1};
  end

  assign sclk_s = sclk_sync_q[G_SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[G_SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[G_SYNC_STAGES-1];

  always_comb begin
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    // A frame may only start after CS has been genuinely seen high since
    // reset, so a CS held low across reset release never starts a frame.
    armed_d     = armed_q | (vld_q[G_SYNC_STAGES] & cs_prev_q & cs_s);
  end

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise   = cs_s & ~cs_prev_q;

  always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
    if (!p_in_rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      vld_q       <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      vld_q       <= vld_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      armed_q     <= armed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM and datapath
  // ---------------------------------------------------------------------------
  state_t     state_q,     state_d;
  logic [4:0] bit_cnt_q,   bit_cnt_d;    // completed SCLK rising edges
  logic [7:0] rx_q,        rx_d;         // MOSI shift register
  logic [7:0] tx_q,        tx_d;         // MISO shift register
  logic       rw_q,        rw_d;
  logic [6:0] addr_q,      addr_d;
  logic [7:0] wdata_q,     wdata_d;
  logic       wr_q,        wr_d;
  logic       rd_q,        rd_d;
  logic       rd_dly_q,    rd_dly_d;     // rdata is valid while this is set
  logic       miso_q,      miso_d;
  logic       frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    rd_dly_d    = rd_q;
    miso_d      = miso_q;
    frame_err_d = 1'b0;

    if (rd_dly_q) begin
      tx_d = p_in_reg_rdata;
    end

    unique case (state_q)
      ST_IDLE: begin
        miso_d = G_MISO_IDLE;
        if (cs_fall) begin
          bit_cnt_d = '0;
          rx_d      = '0;
          state_d   = ST_CMD;
        end
      end

      ST_CMD: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          miso_d      = G_MISO_IDLE;
          state_d     = ST_IDLE;
        end else if (sclk_rise) begin
          rx_d      = {rx_q[6:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            // rx_q[6] is bit15 (R/W), the remaining bits plus MOSI form the
            // address.
            rw_d    = rx_q[6];
            addr_d  = {rx_q[5:0], mosi_s};
            rd_d    = rx_q[6];
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          miso_d      = G_MISO_IDLE;
          state_d     = ST_IDLE;
        end else if (sclk_rise) begin
          rx_d      = {rx_q[6:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            if (!rw_q) begin
              wdata_d = {rx_q[6:0], mosi_s};
              wr_d    = 1'b1;
            end
            miso_d  = G_MISO_IDLE;
            state_d = ST_DONE;
          end
        end else if (sclk_fall && rw_q) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end

      ST_DONE: begin
        miso_d = G_MISO_IDLE;
        if (cs_rise) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
    if (!p_in_rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      rd_dly_q    <= 1'b0;
      miso_q      <= G_MISO_IDLE;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      rd_dly_q    <= rd_dly_d;
      miso_q      <= miso_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign p_out_spi_miso    = miso_q;
  assign p_out_spi_miso_oe = ~cs_s;
  assign p_out_busy        = ~cs_s;
  assign p_out_reg_addr    = addr_q;
  assign p_out_reg_wdata   = wdata_q;
  assign p_out_reg_wr      = wr_q;
  assign p_out_reg_rd      = rd_q;
  assign p_out_frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regbus.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_regbus
//
// Drives SPI frames as a mode-0 host and compares the register-bus activity
// and MISO data of spi_slave_regbus against per-frame expectations derived
// from the frame contents, length and a model register file.
// -----------------------------------------------------------------------------
module tb_spi_slave_regbus;

  localparam logic IDLE_LVL = 1'b0;

  logic       clk;
  logic       rst_n;
  logic       spi_clk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       frame_err;
  logic       busy;

  spi_slave_regbus #(
    .G_SYNC_STAGES(2),
    .G_MISO_IDLE  (IDLE_LVL)
  ) dut (
    .p_in_clk         (clk),
    .p_in_rst_n       (rst_n),
    .p_in_spi_clk     (spi_clk),
    .p_in_spi_cs_n    (spi_cs_n),
    .p_in_spi_mosi    (spi_mosi),
    .p_out_spi_miso   (spi_miso),
    .p_out_spi_miso_oe(spi_miso_oe),
    .p_out_reg_addr   (reg_addr),
    .p_out_reg_wdata  (reg_wdata),
    .p_out_reg_wr     (reg_wr),
    .p_out_reg_rd     (reg_rd),
    .p_in_reg_rdata   (reg_rdata),
    .p_out_frame_err  (frame_err),
    .p_out_busy       (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Peripheral register file (responds to the DUT) and host-side model.
  logic [7:0] pmem      [0:127];
  logic [7:0] model_mem [0:127];

  int         wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
  logic [6:0] wr_addr_last, rd_addr_last;
  logic [7:0] wr_data_last;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Bus monitor: counts strobes and records the bus values they carried.
  initial begin
    forever begin
      @(negedge clk);
      if (reg_wr) begin
        wr_cnt++;
        wr_addr_last = reg_addr;
        wr_data_last = reg_wdata;
        pmem[reg_addr] = reg_wdata;
      end
      if (reg_rd) begin
        rd_cnt++;
        rd_addr_last = reg_addr;
      end
      if (frame_err) err_cnt++;
    end
  end

  // Read responder: data valid only in the cycle after rd, junk otherwise.
  initial begin
    bit         rd_seen;
    logic [6:0] rd_a;
    rd_seen   = 1'b0;
    rd_a      = '0;
    reg_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_seen) reg_rdata = pmem[rd_a];
      else         reg_rdata = 8'($urandom);
      rd_seen = reg_rd;
      rd_a    = reg_addr;
    end
  end

  // Mode-0 host transfer of nclk SCLK cycles; bits past 16 are random.
  task automatic spi_xfer(input logic [15:0] frame, input int unsigned nclk,
                          input int unsigned half, input bit raise_cs,
                          output logic [7:0] rd_byte, output logic [7:0] tail_byte,
                          output bit oe_ok);
    rd_byte   = {8{IDLE_LVL}};
    tail_byte = {8{IDLE_LVL}};
    oe_ok     = 1'b1;
    spi_cs_n  = 1'b0;
    wait_clk(half);
    for (int unsigned i = 0; i < nclk; i++) begin
      spi_mosi = (i < 16) ? frame[15-i] : 1'($urandom);
      wait_clk(half);
      spi_clk = 1'b1;
      if (i >= 8 && i < 16)  rd_byte[15-i]   = spi_miso;
      if (i >= 16 && i < 24) tail_byte[23-i] = spi_miso;
      if (spi_miso_oe !== 1'b1) oe_ok = 1'b0;
      wait_clk(half);
      spi_clk = 1'b0;
    end
    wait_clk(half);
    if (raise_cs) spi_cs_n = 1'b1;
  endtask

  task automatic run_frame(input logic [15:0] frame, input int unsigned nclk,
                           input int unsigned half, input int unsigned gap);
    int         wr0, rd0, er0;
    logic [7:0] rb, tl;
    bit         ok, rw, full, exp_wr, exp_rd;
    logic [6:0] a;
    logic [7:0] d;
    wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
    rw  = frame[15];
    a   = frame[14:8];
    d   = frame[7:0];
    full   = (nclk >= 16);
    exp_wr = full && !rw;
    exp_rd = rw && (nclk >= 8);
    spi_xfer(frame, nclk, half, 1'b1, rb, tl, ok);
    wait_clk(8);
    check_val("wr_pulses",  32'(wr_cnt - wr0),  32'(exp_wr));
    check_val("rd_pulses",  32'(rd_cnt - rd0),  32'(exp_rd));
    check_val("err_pulses", 32'(err_cnt - er0), 32'(!full));
    if (exp_wr) begin
      check_val("wr_addr", 32'(wr_addr_last), 32'(a));
      check_val("wr_data", 32'(wr_data_last), 32'(d));
      model_mem[a] = d;
    end
    if (exp_rd) check_val("rd_addr", 32'(rd_addr_last), 32'(a));
    if (nclk >= 8) check_val("addr_hold", 32'(reg_addr), 32'(a));
    if (full && rw)   check_val("miso_rdata", 32'(rb), 32'(model_mem[a]));
    else if (full)    check_val("miso_wr_idle", 32'(rb), 32'({8{IDLE_LVL}}));
    if (nclk > 16)    check_val("miso_tail_idle", 32'(tl), 32'({8{IDLE_LVL}}));
    check_val("oe_in_frame", 32'(ok), 32'd1);
    wait_clk(2);
    check_val("oe_gap",   32'(spi_miso_oe), 32'd0);
    check_val("busy_gap", 32'(busy), 32'd0);
    wait_clk(gap - 10);
  endtask

  task automatic check_reset_outputs(input string phase);
    check_val({phase, "_addr"},  32'(reg_addr),    32'd0);
    check_val({phase, "_wdata"}, 32'(reg_wdata),   32'd0);
    check_val({phase, "_strb"},  32'({reg_wr, reg_rd, frame_err}), 32'd0);
    check_val({phase, "_busy"},  32'({busy, spi_miso_oe}), 32'd0);
    check_val({phase, "_miso"},  32'(spi_miso),    32'(IDLE_LVL));
  endtask

  initial begin
    logic [7:0] rb, tl;
    bit         ok;
    int         wr0, rd0, er0;
    int unsigned kind, nclk;

    rst_n    = 1'b0;
    spi_clk  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    for (int i = 0; i < 128; i++) begin
      pmem[i]      = 8'($urandom);
      model_mem[i] = pmem[i];
    end
    wait_clk(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    wait_clk(10);

    // Directed frames.
    run_frame(16'h2A5C, 16, 5, 20);
    pmem[7'h2A] = 8'hC3; model_mem[7'h2A] = 8'hC3;
    run_frame(16'hAA00, 16, 5, 20);
    run_frame(16'h1177, 12, 5, 20);
    run_frame(16'h1177, 16, 5, 20);
    run_frame(16'h0312, 24, 5, 20);

    // Reset in the middle of a read, CS still low at reset release.
    spi_xfer(16'h9500, 10, 5, 1'b0, rb, tl, ok);
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(10);
    // Clocking a frame with CS never having risen must not start anything.
    spi_xfer(16'h0455, 16, 5, 1'b1, rb, tl, ok);
    wait_clk(10);
    check_val("postrst_no_wr",  32'(wr_cnt - wr0),  32'd0);
    check_val("postrst_no_rd",  32'(rd_cnt - rd0),  32'd0);
    check_val("postrst_no_err", 32'(err_cnt - er0), 32'd0);
    check_val("postrst_addr",   32'(reg_addr),      32'd0);
    run_frame(16'h8100, 16, 5, 20);

    // Back-to-back at the SCLK limit with a two-period CS gap.
    run_frame({1'b0, 15'($urandom)}, 16, 5, 20);
    run_frame({1'b1, 15'($urandom)}, 16, 5, 20);

    // Randomized frames: normal, aborted and overlong.
    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 3);
      if (kind == 2)      nclk = $urandom_range(1, 15);
      else if (kind == 3) nclk = 24;
      else                nclk = 16;
      run_frame(16'($urandom), nclk, $urandom_range(5, 8), $urandom_range(20, 30));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
